gfx_reg_writer: RTL

GFX_REG_WRITER -- requirements
Module: gfx_reg_writer

---
 rtl/gfx_reg_writer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gfx_reg_writer.sv
// Queued register-write engine: a FIFO of {addr,data} drained through a SETUP/STROBE/RECOVER chipselect sequence.
// Optional macro GFX_VSYNC_GATE_EN restricts write launches to vertical blanking.
module gfx_reg_writer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        vblank,
  output logic        chipselect,
  output logic [3:0]  data_address,
  output logic [15:0] databus,
  output logic        busy,
  output logic [6:0]  level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] STROBE  = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nx;
  logic          cs_nx;
  logic [3:0]    addr_nx;
  logic [15:0]   data_nx;
  logic [6:0]    level_nx;
  logic          ready_nx;
  logic          busy_nx;
  logic          empty;
  logic          launch;
  logic          push;
  logic          pop;

`ifdef GFX_VSYNC_GATE_EN
  assign launch = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign launch        = 1'b1;
`endif

  assign empty = (level == 7'd0);
  assign push  = wr_valid & wr_ready;
  // Pops only happen where a new write may start: from IDLE or straight out of RECOVER.
  assign pop   = ((state == IDLE) || (state == RECOVER)) && !empty && launch;

  // Next-state, strobe and output-register computation.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cs_nx    = chipselect;
    addr_nx  = data_address;
    data_nx  = databus;
    case (state)
      IDLE, RECOVER: begin
        cs_nx  = 1'b0;
        cnt_nx = 4'd0;
        if (pop) begin
          state_nx = SETUP;
          addr_nx  = mem[rptr][19:16];
          data_nx  = mem[rptr][15:0];
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cs_nx    = 1'b1;
        cnt_nx   = 4'd1;
      end
      STROBE: begin
        if (cnt == 4'(HOLD_CYCLES)) begin
          state_nx = RECOVER;
          cs_nx    = 1'b0;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx   = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cs_nx    = 1'b0;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Occupancy, ready and busy follow the same edge as the push/pop.
  always_comb begin
    level_nx = level;
    case ({push, pop})
      2'b10:   level_nx = level + 7'd1;
      2'b01:   level_nx = level - 7'd1;
      default: level_nx = level;
    endcase
    ready_nx = (level_nx != 7'(DEPTH));
    busy_nx  = (state_nx != IDLE) || (level_nx != 7'd0);
  end

  // FIFO storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {wr_addr, wr_data};
    end
  end

  // Control and output registers; reset drops chipselect asynchronously and discards the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      chipselect   <= 1'b0;
      data_address <= 4'd0;
      databus      <= 16'd0;
      level        <= 7'd0;
      wr_ready     <= 1'b1;
      busy         <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      chipselect   <= cs_nx;
      data_address <= addr_nx;
      databus      <= data_nx;
      level        <= level_nx;
      wr_ready     <= ready_nx;
      busy         <= busy_nx;
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

endmodule
